// File: rtl/sobel_window_buffer_if.sv
// Pixel-stream and window-stream bundle between the SRAM reader, the Sobel
// window buffer and the gradient stage.
interface sobel_window_buffer_if #(
    parameter int PIX_W = 8
);
    logic [PIX_W-1:0]   pix_in;
    logic               pix_valid;
    logic               pix_ready;
    logic [9*PIX_W-1:0] window;
    logic               win_valid;
    logic               win_ready;

    modport master (
        output pix_in, pix_valid, win_ready,
        input  pix_ready, window, win_valid
    );

    modport slave (
        input  pix_in, pix_valid, win_ready,
        output pix_ready, window, win_valid
    );
endinterface

// File: rtl/sobel_window_buffer.sv
// Assembles the 3x3 Sobel window from the serpentine SRAM read stream.
// Optional macro SOBEL_WINBUF_COUNT_EN adds the win_count handshake counter.
module sobel_window_buffer #(
    parameter int PIX_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_fill,
    input  logic        start_update,
    input  logic [1:0]  direction,
    output logic        busy,
    output logic        seq_err,
`ifdef SOBEL_WINBUF_COUNT_EN
    output logic [15:0] win_count,
`endif
    sobel_window_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_FILL    = 2'd1,
        ST_UPDATE  = 2'd2,
        ST_PRESENT = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [3:0]         count_r;
    logic [1:0]         dir_r;
    logic               seq_err_r;
    logic [PIX_W-1:0]   win_r [0:8];

    logic               pix_ready_s;
    logic               win_valid_s;
    logic               busy_s;
    logic               pix_acc_s;
    logic               last_pix_s;
    logic               upd_start_s;
    logic               seq_err_set_s;
    logic [3:0]         wr_idx_s;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake qualifiers and the window slot the next accepted pixel lands in
    always_comb begin
        pix_acc_s     = bus.pix_valid && pix_ready_s;
        upd_start_s   = (state_r == ST_IDLE) && start_update && (direction != 2'b00);
        seq_err_set_s = start_update && !start_fill &&
                        ((state_r != ST_IDLE) || (direction == 2'b00));
        wr_idx_s      = count_r;
        last_pix_s    = 1'b0;
        case (state_r)
            ST_FILL: begin
                wr_idx_s   = count_r;
                last_pix_s = (count_r == 4'd8);
            end
            ST_UPDATE: begin
                last_pix_s = (count_r == 4'd2);
                case (dir_r)
                    2'b01:   wr_idx_s = 4'd3 * count_r + 4'd2;
                    2'b10:   wr_idx_s = 4'd3 * count_r;
                    2'b11:   wr_idx_s = 4'd6 + count_r;
                    default: wr_idx_s = count_r;
                endcase
            end
            default: begin
                wr_idx_s   = count_r;
                last_pix_s = 1'b0;
            end
        endcase
    end

    // Next-state decode; a fill request pre-empts every state
    always_comb begin
        state_nxt_s = state_r;
        if (start_fill) begin
            state_nxt_s = ST_FILL;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (upd_start_s) state_nxt_s = ST_UPDATE;
                    else             state_nxt_s = ST_IDLE;
                end
                ST_FILL, ST_UPDATE: begin
                    if (pix_acc_s && last_pix_s) state_nxt_s = ST_PRESENT;
                    else                         state_nxt_s = state_r;
                end
                ST_PRESENT: begin
                    if (bus.win_ready) state_nxt_s = ST_IDLE;
                    else               state_nxt_s = ST_PRESENT;
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // Output decode from the registered state
    always_comb begin
        pix_ready_s = 1'b0;
        win_valid_s = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_FILL, ST_UPDATE: begin
                pix_ready_s = 1'b1;
                busy_s      = 1'b1;
            end
            ST_PRESENT: begin
                win_valid_s = 1'b1;
                busy_s      = 1'b1;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Window storage: shift on update start, then refill the vacated line
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r   <= 4'd0;
            dir_r     <= 2'b00;
            seq_err_r <= 1'b0;
            for (int i = 0; i < 9; i++) begin
                win_r[i] <= {PIX_W{1'b0}};
            end
        end else begin
            if (seq_err_set_s) begin
                seq_err_r <= 1'b1;
            end
            if (start_fill) begin
                count_r <= 4'd0;
            end else if (upd_start_s) begin
                dir_r   <= direction;
                count_r <= 4'd0;
                case (direction)
                    2'b01: begin
                        win_r[0] <= win_r[1]; win_r[1] <= win_r[2];
                        win_r[3] <= win_r[4]; win_r[4] <= win_r[5];
                        win_r[6] <= win_r[7]; win_r[7] <= win_r[8];
                    end
                    2'b10: begin
                        win_r[2] <= win_r[1]; win_r[1] <= win_r[0];
                        win_r[5] <= win_r[4]; win_r[4] <= win_r[3];
                        win_r[8] <= win_r[7]; win_r[7] <= win_r[6];
                    end
                    2'b11: begin
                        win_r[0] <= win_r[3]; win_r[1] <= win_r[4]; win_r[2] <= win_r[5];
                        win_r[3] <= win_r[6]; win_r[4] <= win_r[7]; win_r[5] <= win_r[8];
                    end
                    default: begin
                        dir_r <= direction;
                    end
                endcase
            end else if (pix_acc_s) begin
                win_r[wr_idx_s] <= bus.pix_in;
                count_r         <= last_pix_s ? 4'd0 : count_r + 4'd1;
            end
        end
    end

`ifdef SOBEL_WINBUF_COUNT_EN
    logic [15:0] win_count_r;

    // Completed-handshake tally; restarting the image clears it
    always_ff @(posedge clk) begin
        if (reset) begin
            win_count_r <= 16'd0;
        end else if (start_fill) begin
            win_count_r <= 16'd0;
        end else if (win_valid_s && bus.win_ready) begin
            win_count_r <= win_count_r + 16'd1;
        end
    end

    assign win_count = win_count_r;
`endif

    for (genvar gi = 0; gi < 9; gi++) begin : g_win
        assign bus.window[PIX_W*gi +: PIX_W] = win_r[gi];
    end

    assign bus.pix_ready = pix_ready_s;
    assign bus.win_valid = win_valid_s;
    assign busy          = busy_s;
    assign seq_err       = seq_err_r;

endmodule

// File: tb/tb_sobel_window_buffer.sv
// Randomized bench for sobel_window_buffer against a 3x3-array reference model,
// plus literal window expectations for the basic fill and update moves.
module tb_sobel_window_buffer;

    logic        clk;
    logic        reset;
    logic        start_fill;
    logic        start_update;
    logic [1:0]  direction;
    logic        busy;
    logic        seq_err;
`ifdef SOBEL_WINBUF_COUNT_EN
    logic [15:0] win_count;
`endif

    sobel_window_buffer_if #(.PIX_W(8)) bus();

    sobel_window_buffer #(.PIX_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start_fill   (start_fill),
        .start_update (start_update),
        .direction    (direction),
        .busy         (busy),
        .seq_err      (seq_err),
`ifdef SOBEL_WINBUF_COUNT_EN
        .win_count    (win_count),
`endif
        .bus          (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 3x3 array, collection mode and pixel index
    logic [7:0]  m_win [0:2][0:2];
    int          m_mode;   // 0 idle, 1 filling, 2 updating, 3 presenting
    int          m_n;
    logic [1:0]  m_dir;
    logic        m_err;
    logic [15:0] m_cnt;

    function automatic logic [71:0] model_window();
        logic [71:0] v;
        for (int i = 0; i < 9; i++) v[8*i +: 8] = m_win[i/3][i%3];
        return v;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_mode <= 0; m_n <= 0; m_err <= 1'b0; m_cnt <= 16'd0; m_dir <= 2'b00;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++) m_win[r][c] <= 8'h00;
        end else begin
            if (start_update && !start_fill && (m_mode != 0 || direction == 2'b00)) m_err <= 1'b1;
            if (start_fill) begin
                m_mode <= 1; m_n <= 0; m_cnt <= 16'd0;
            end else begin
                if (m_mode == 3 && bus.win_ready) begin
                    m_mode <= 0; m_cnt <= m_cnt + 16'd1;
                end
                if (m_mode == 0 && start_update && direction != 2'b00) begin
                    m_dir <= direction; m_mode <= 2; m_n <= 0;
                    for (int r = 0; r < 3; r++) begin
                        if (direction == 2'b01) begin
                            m_win[r][0] <= m_win[r][1]; m_win[r][1] <= m_win[r][2];
                        end else if (direction == 2'b10) begin
                            m_win[r][2] <= m_win[r][1]; m_win[r][1] <= m_win[r][0];
                        end else if (r < 2) begin
                            for (int c = 0; c < 3; c++) m_win[r][c] <= m_win[r+1][c];
                        end
                    end
                end
                if ((m_mode == 1 || m_mode == 2) && bus.pix_valid) begin
                    if (m_mode == 1)        m_win[m_n/3][m_n%3] <= bus.pix_in;
                    else if (m_dir == 2'b01) m_win[m_n][2] <= bus.pix_in;
                    else if (m_dir == 2'b10) m_win[m_n][0] <= bus.pix_in;
                    else                     m_win[2][m_n] <= bus.pix_in;
                    if (m_n == (m_mode == 1 ? 8 : 2)) begin
                        m_mode <= 3; m_n <= 0;
                    end else begin
                        m_n <= m_n + 1;
                    end
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("pix_ready", 72'(bus.pix_ready), 72'(m_mode == 1 || m_mode == 2));
            check("win_valid", 72'(bus.win_valid), 72'(m_mode == 3));
            check("busy",      72'(busy),          72'(m_mode != 0));
            check("seq_err",   72'(seq_err),       72'(m_err));
            check("window",    bus.window,         model_window());
`ifdef SOBEL_WINBUF_COUNT_EN
            check("win_count", 72'(win_count),     72'(m_cnt));
`endif
        end
    end

    task automatic next();
        @(negedge clk);
        start_fill   = 1'b0;
        start_update = 1'b0;
        bus.pix_valid = 1'b0;
    endtask

    task automatic feed(input logic [71:0] pv, input int n, input bit gaps, input bit spur);
        int i = 0;
        int budget = 0;
        while (i < n && budget < 300) begin
            next();
            if (!gaps || $urandom_range(0, 3) != 0) begin
                bus.pix_valid = 1'b1;
                bus.pix_in    = pv[8*i +: 8];
            end else begin
                bus.pix_in    = 8'($urandom);
            end
            if (spur && $urandom_range(0, 7) == 0) begin
                start_update = 1'b1;
                direction    = 2'($urandom);
            end
            if (bus.pix_valid && bus.pix_ready) i++;
            budget++;
        end
        if (i < n) begin
            checks++; errors++;
            $display("FAIL feed_timeout accepted=%0d required=%0d", i, n);
        end
    endtask

    task automatic drain(input logic [71:0] lit, input bit use_lit, input bit spur);
        int b = 0;
        next();
        while (!bus.win_valid && b < 50) begin
            next();
            b++;
        end
        if (!bus.win_valid) begin
            checks++; errors++;
            $display("FAIL drain_timeout win_valid=0 required=1");
        end else if (use_lit) begin
            check("lit_window", bus.window, lit);
        end
        repeat ($urandom_range(0, 3)) begin
            next();
            bus.pix_valid = 1'($urandom);
            bus.pix_in    = 8'($urandom);
        end
        next();
        bus.win_ready = 1'b1;
        if (spur && $urandom_range(0, 3) == 0) begin
            start_update = 1'b1;
            direction    = 2'($urandom);
        end
        next();
        bus.win_ready = 1'b0;
    endtask

    task automatic do_fill(input logic [71:0] pv);
        next();
        start_fill = 1'b1;
        feed(pv, 9, 1'b1, 1'b0);
        drain(pv, 1'b1, 1'b0);
    endtask

    task automatic do_update(input logic [1:0] d, input logic [71:0] pv, input logic [71:0] lit);
        next();
        start_update = 1'b1;
        direction    = d;
        feed(pv, 3, 1'b1, 1'b0);
        drain(lit, 1'b1, 1'b0);
    endtask

    localparam logic [71:0] T1 = 72'h09_08_07_06_05_04_03_02_01;

    initial begin
        logic [71:0] rp;
        reset = 1'b1; start_fill = 1'b0; start_update = 1'b0; direction = 2'b00;
        bus.pix_in = 8'h00; bus.pix_valid = 1'b0; bus.win_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        cmp_en = 1'b1;
        check("rst_window",    bus.window,          72'h0);
        check("rst_win_valid", 72'(bus.win_valid),  72'h0);
        check("rst_pix_ready", 72'(bus.pix_ready),  72'h0);
        check("rst_busy",      72'(busy),           72'h0);
        reset = 1'b0;

        // Back-to-back fill, gradient stage always ready
        bus.win_ready = 1'b1;
        next();
        start_fill = 1'b1;
        feed(T1, 9, 1'b0, 1'b0);
        next();
        check("t1_win_valid", 72'(bus.win_valid), 72'h1);
        check("t1_window",    bus.window,         T1);
        next();
        check("t1_valid_once", 72'(bus.win_valid), 72'h0);
        bus.win_ready = 1'b0;

        do_fill(T1);
        do_update(2'b01, 72'h0C_0B_0A, 72'h0C_09_08_0B_06_05_0A_03_02);
        do_fill(T1);
        do_update(2'b10, 72'hA2_A1_A0, 72'h08_07_A2_05_04_A1_02_01_A0);
        do_fill(T1);
        do_update(2'b11, 72'hB2_B1_B0, 72'hB2_B1_B0_09_08_07_06_05_04);

        // Abort a fill after four pixels
        next();
        start_fill = 1'b1;
        feed(72'h44_33_22_11, 4, 1'b1, 1'b0);
        next();
        start_fill = 1'b1;
        feed(72'h99_88_77_66_55_44_33_22_11, 9, 1'b1, 1'b0);
        drain(72'h99_88_77_66_55_44_33_22_11, 1'b1, 1'b0);

        // Reset while presenting
        next();
        start_fill = 1'b1;
        feed(T1, 9, 1'b0, 1'b0);
        next();
        check("pre_rst_valid", 72'(bus.win_valid), 72'h1);
        reset = 1'b1;
        next();
        reset = 1'b0;
        check("post_rst_valid",  72'(bus.win_valid), 72'h0);
        check("post_rst_window", bus.window,         72'h0);

        do_fill(T1);
        do_update(2'b01, 72'h0C_0B_0A, 72'h0C_09_08_0B_06_05_0A_03_02);
        do_update(2'b11, 72'hB2_B1_B0, 72'hB2_B1_B0_0C_09_08_0B_06_05);
`ifdef SOBEL_WINBUF_COUNT_EN
        check("win_count_3", 72'(win_count), 72'd3);
`endif

        // Stalled gradient stage: pixels dropped, late update flagged
        next();
        start_fill = 1'b1;
        feed(T1, 9, 1'b0, 1'b0);
        repeat (5) begin
            next();
            bus.pix_valid = 1'b1;
            bus.pix_in    = 8'($urandom);
            check("stall_pix_ready", 72'(bus.pix_ready), 72'h0);
        end
        next();
        start_update = 1'b1;
        direction    = 2'b01;
        next();
        check("stall_seq_err", 72'(seq_err),   72'h1);
        check("stall_window",  bus.window,     T1);
        bus.win_ready = 1'b1;
        next();
        bus.win_ready = 1'b0;
        next();
        check("stall_idle", 72'(busy), 72'h0);

        // Randomized operation mix
        for (int k = 0; k < 80; k++) begin
            int op;
            op = $urandom_range(0, 9);
            rp = {$urandom, $urandom, $urandom};
            if (op <= 2) begin
                next();
                start_fill   = 1'b1;
                start_update = 1'($urandom);
                direction    = 2'($urandom);
                if ($urandom_range(0, 4) == 0) begin
                    feed(rp, 3, 1'b1, 1'b1);
                    next();
                    start_fill = 1'b1;
                end
                feed(rp, 9, 1'b1, 1'b1);
                drain(rp, 1'b0, 1'b1);
            end else if (op <= 8) begin
                next();
                start_update = 1'b1;
                direction    = ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                if (direction != 2'b00) begin
                    feed(rp, 3, 1'b1, 1'b1);
                    drain(rp, 1'b0, 1'b1);
                end
            end else begin
                repeat ($urandom_range(1, 4)) begin
                    next();
                    bus.pix_valid = 1'($urandom);
                    bus.pix_in    = 8'($urandom);
                    bus.win_ready = 1'($urandom);
                end
                next();
                bus.win_ready = 1'b0;
            end
        end

        next();
        next();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
